// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Width decode, byte-enable generation and store-lane replication live here.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MW_B = 2'b00,
    MW_H = 2'b01,
    MW_W = 2'b10,
    MW_X = 2'b11
  } mem_width_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic width_fault(mem_width_e w, logic [1:0] a);
    case (w)
      MW_B:    return 1'b0;
      MW_H:    return a[0];
      MW_W:    return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(mem_width_e w, logic [1:0] a);
    case (w)
      MW_B:    return 4'b0001 << a;
      MW_H:    return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(mem_width_e w, logic [31:0] d);
    case (w)
      MW_B:    return {4{d[7:0]}};
      MW_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load formatter: moves the addressed lane down to bit 0
// and sign- or zero-extends it according to func3.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  func3,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {a, 3'b000};

  always_comb begin
    case (func3)
      F3_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  ld_data = {24'h0, shifted[7:0]};
      F3_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  ld_data = {16'h0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: runs one access at a time on a valid/ready
// bus, stalls the pipeline while it is outstanding and formats load results.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_en,
  input  logic        st_en,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        st_done,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_we,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_be,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_err
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  func3_q, func3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] ld_hold_q, ld_hold_d;

  logic        op;
  logic        fault;
  mem_width_e  width;
  logic        stall_c;
  logic        misalign_c;
  logic [31:0] ld_fmt;

  assign op    = ld_en | st_en;
  assign width = mem_width_e'(func3[1:0]);
  assign fault = width_fault(width, addr[1:0]);

  load_align u_load_align (
    .rdata   (rdata_q),
    .a       (addr_q[1:0]),
    .func3   (func3_q),
    .ld_data (ld_fmt)
  );

  // NOTE: every signal gets its default first so no branch can infer a latch.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    func3_d    = func3_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ld_hold_d  = ld_hold_q;
    stall_c    = 1'b0;
    misalign_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op) begin
          if (fault) begin
            misalign_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            we_d    = st_en;
            addr_d  = addr;
            be_d    = byte_en(width, addr[1:0]);
            wdata_d = store_lanes(width, wdata);
            func3_d = func3;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        if (bus_req_ready) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (bus_rsp_valid) begin
          rdata_d = bus_rsp_rdata;
          err_d   = bus_rsp_err;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // A timed-out load returns zero rather than a stale word.
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!we_q) ld_hold_d = ld_fmt;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      func3_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ld_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      func3_q   <= func3_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ld_hold_q <= ld_hold_d;
    end
  end

  assign stall         = stall_c & ~rst;
  assign misalign      = misalign_c & ~rst;
  assign bus_req_valid = (state_q == ST_REQ);
  assign bus_req_we    = we_q;
  assign bus_req_addr  = {addr_q[31:2], 2'b00};
  assign bus_req_wdata = wdata_q;
  assign bus_req_be    = be_q;
  assign ld_valid      = (state_q == ST_DONE) & ~we_q;
  assign st_done       = (state_q == ST_DONE) & we_q;
  assign bus_err       = (state_q == ST_DONE) & err_q;
  assign ld_data       = ld_valid ? ld_fmt : ld_hold_q;

endmodule
